// File: rtl/alureg_seq_if.sv
// Byte-stream handshake between the bus interface unit (master) and alureg_seq (slave).
interface alureg_seq_if #(
    parameter int DATASIZE = 8
);
    logic [DATASIZE-1:0] in_data;
    logic                in_valid;
    logic                in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/alureg_seq.sv
// Self-sequencing 8085-style register file and ALU: decodes MOV/MVI/ALU/HLT from a byte stream.
// state | meaning
// FETCH | waiting for a code byte
// DATA  | waiting for the immediate byte
// READ  | latch operand (register or immediate) into temp
// WRITE | write destination (and F for ALU ops)
// HALT  | stopped until reset
module alureg_seq #(
    parameter int DATASIZE = 8,
    parameter int INSTSIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    alureg_seq_if.slave         bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                halted,
    output logic [INSTSIZE-1:0] inst_q,
    input  logic [2:0]          dbg_sel,
    output logic [DATASIZE-1:0] dbg_data
);
    typedef enum logic [2:0] {S_FETCH, S_DATA, S_READ, S_WRITE, S_HALT} state_t;

    localparam logic [2:0] REG_F = 3'd6;
    localparam logic [2:0] REG_A = 3'd7;
    localparam logic [2:0] OP_CMP = 3'b111;

    state_t               state_q, state_d;
    logic [INSTSIZE-1:0]  inst_d;
    logic [DATASIZE-1:0]  temp_q, temp_d;
    logic [DATASIZE-1:0]  regs_q [8];
    logic [DATASIZE-1:0]  regs_d [8];
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 in_ready_c;

    logic [7:0]           code;
    logic                 accept;
    logic                 code_ok;
    logic [2:0]           op, src, dst;
    logic                 cin;
    logic [DATASIZE:0]    sum;
    logic [4:0]           nib;
    logic [DATASIZE-1:0]  alu_res;
    logic [DATASIZE-1:0]  flags;

    assign code    = bus.in_data[7:0];
    assign accept  = bus.in_valid && in_ready_c;
    assign code_ok = code[7] ^ code[6];
    assign op      = inst_q[5:3];
    assign dst     = inst_q[5:3];
    assign src     = inst_q[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            inst_q  <= '0;
            temp_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            temp_q  <= temp_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (accept && code_ok) begin
                    if (code == 8'h76)          state_d = S_HALT;
                    else if (code[2:0] == 3'b110) state_d = S_DATA;
                    else                        state_d = S_READ;
                end
            end
            S_DATA:  if (accept) state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: in_ready_c = 1'b1;
            S_DATA: begin
                in_ready_c = 1'b1;
                busy       = 1'b1;
            end
            S_READ, S_WRITE: busy = 1'b1;
            S_HALT:  halted = 1'b1;
            default: in_ready_c = 1'b0;
        endcase
    end

    // Borrow/carry falls out of the extra top bit for both add and subtract.
    always_comb begin
        cin = (op == 3'b001 || op == 3'b011) ? regs_q[REG_F][0] : 1'b0;
        sum = '0;
        nib = '0;
        case (op)
            3'b000, 3'b001: begin
                sum = {1'b0, regs_q[REG_A]} + {1'b0, temp_q} + {{DATASIZE{1'b0}}, cin};
                nib = {1'b0, regs_q[REG_A][3:0]} + {1'b0, temp_q[3:0]} + {4'b0, cin};
            end
            3'b010, 3'b011, 3'b111: begin
                sum = {1'b0, regs_q[REG_A]} - {1'b0, temp_q} - {{DATASIZE{1'b0}}, cin};
                nib = {1'b0, regs_q[REG_A][3:0]} - {1'b0, temp_q[3:0]} - {4'b0, cin};
            end
            3'b100:  sum = {1'b0, regs_q[REG_A] & temp_q};
            3'b101:  sum = {1'b0, regs_q[REG_A] ^ temp_q};
            default: sum = {1'b0, regs_q[REG_A] | temp_q};
        endcase
        alu_res  = sum[DATASIZE-1:0];
        flags    = '0;
        flags[7] = alu_res[DATASIZE-1];
        flags[6] = (alu_res == '0);
        flags[4] = nib[4];
        flags[2] = ~^alu_res[7:0];
        flags[0] = sum[DATASIZE];
    end

    always_comb begin
        inst_d = inst_q;
        temp_d = temp_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
        case (state_q)
            S_FETCH: begin
                if (accept) begin
                    inst_d = code[INSTSIZE-1:0];
                    err_d  = !code_ok;
                end
            end
            S_DATA:  if (accept) temp_d = bus.in_data;
            S_READ:  temp_d = (src == 3'b110) ? temp_q : regs_q[src];
            S_WRITE: begin
                done_d = 1'b1;
                if (inst_q[7:6] == 2'b01) begin
                    regs_d[dst] = temp_q;
                end else begin
                    regs_d[REG_F] = flags;
                    if (op != OP_CMP) regs_d[REG_A] = alu_res;
                end
            end
            default: inst_d = inst_q;
        endcase
    end

    assign bus.in_ready = in_ready_c;
    assign done         = done_q;
    assign err          = err_q;
    assign dbg_data     = regs_q[dbg_sel];
endmodule

// File: tb/tb_alureg_seq.sv
// Directed and randomized bench for alureg_seq against an instruction-level reference model.
module tb_alureg_seq;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    dbg_sel = 3'd0;
    logic          busy, done, err, halted;
    logic [7:0]    inst_q;
    logic [DW-1:0] dbg_data;

    alureg_seq_if #(.DATASIZE(DW)) bus ();

    alureg_seq #(.DATASIZE(DW), .INSTSIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .halted   (halted),
        .inst_q   (inst_q),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always #10 clk = ~clk;

    logic       exp_rdy, exp_busy, exp_done, exp_err, exp_halt;
    logic [7:0] exp_inst;
    logic [7:0] exp_regs [8];
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Outputs are sampled mid-cycle; all eight registers are swept through dbg_sel.
    always @(negedge clk) begin
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        chk("busy",     {31'b0, busy},         {31'b0, exp_busy});
        chk("done",     {31'b0, done},         {31'b0, exp_done});
        chk("err",      {31'b0, err},          {31'b0, exp_err});
        chk("halted",   {31'b0, halted},       {31'b0, exp_halt});
        chk("inst_q",   {24'b0, inst_q},       {24'b0, exp_inst});
        for (int i = 0; i < 8; i++) begin
            dbg_sel = i[2:0];
            #1;
            chk($sformatf("reg%0d", i), {24'b0, dbg_data}, {24'b0, exp_regs[i]});
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
        exp_inst = 8'h00;
        exp_rdy  = 1'b1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_halt = 1'b0;
    endtask

    task automatic model_exec(input logic [7:0] code, input logic [7:0] imm);
        int a, b, c, r, lo;
        bit cy, ac, arith;
        int s;
        s = code[2:0];
        b = (s == 6) ? int'(imm) : int'(exp_regs[s]);
        if (code[7:6] == 2'b01) begin
            exp_regs[code[5:3]] = b[7:0];
        end else begin
            a = exp_regs[7];
            c = exp_regs[6][0];
            arith = 1'b1;
            case (code[5:3])
                3'd0: begin r = a + b;     lo = (a % 16) + (b % 16);     end
                3'd1: begin r = a + b + c; lo = (a % 16) + (b % 16) + c; end
                3'd2: begin r = a - b;     lo = (a % 16) - (b % 16);     end
                3'd3: begin r = a - b - c; lo = (a % 16) - (b % 16) - c; end
                3'd4: begin r = a & b; lo = 0; arith = 1'b0; end
                3'd5: begin r = a ^ b; lo = 0; arith = 1'b0; end
                3'd6: begin r = a | b; lo = 0; arith = 1'b0; end
                default: begin r = a - b; lo = (a % 16) - (b % 16); end
            endcase
            cy = arith && (r > 255 || r < 0);
            ac = arith && (lo > 15 || lo < 0);
            r  = r & 255;
            exp_regs[6] = ((r >= 128) ? 8'h80 : 8'h00) | ((r == 0) ? 8'h40 : 8'h00)
                        | (ac ? 8'h10 : 8'h00) | (($countones(r) % 2 == 0) ? 8'h04 : 8'h00)
                        | (cy ? 8'h01 : 8'h00);
            if (code[5:3] != 3'd7) exp_regs[7] = r[7:0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat (n) step();
    endtask

    // Called in a cycle where the block is expected in FETCH; the code byte is offered immediately.
    task automatic do_instr(input logic [7:0] code, input logic [7:0] imm, input int wt);
        bus.in_valid = 1'b1;
        bus.in_data  = code;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        exp_inst = code;
        if (code[7:6] == 2'b00 || code[7:6] == 2'b11) begin
            exp_err = 1'b1;
            return;
        end
        if (code == 8'h76) begin
            exp_halt = 1'b1;
            exp_rdy  = 1'b0;
            return;
        end
        if (code[2:0] == 3'b110) begin
            exp_busy = 1'b1;
            repeat (wt) step();
            bus.in_valid = 1'b1;
            bus.in_data  = imm;
            step();
        end
        exp_rdy  = 1'b0;
        exp_busy = 1'b1;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 8'($urandom);
        step();
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 8'($urandom);
        step();
        bus.in_valid = 1'b0;
        model_exec(code, imm);
        exp_done = 1'b1;
        exp_rdy  = 1'b1;
        exp_busy = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] code;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        do_instr(8'h7E, 8'hAA, 0);
        chk("pin_t1_A", {24'b0, exp_regs[7]}, 32'hAA);
        chk("pin_t1_F", {24'b0, exp_regs[6]}, 32'h00);

        do_instr(8'h47, 8'h00, 0);
        chk("pin_t2_B", {24'b0, exp_regs[0]}, 32'hAA);
        do_instr(8'hAF, 8'h00, 0);
        chk("pin_t2_A", {24'b0, exp_regs[7]}, 32'h00);
        chk("pin_t2_F", {24'b0, exp_regs[6]}, 32'h44);
        do_instr(8'h4F, 8'h00, 0);
        chk("pin_t2_C", {24'b0, exp_regs[1]}, 32'h00);

        do_instr(8'h7E, 8'hFF, 1);
        do_instr(8'h86, 8'h01, 0);
        chk("pin_t3_A", {24'b0, exp_regs[7]}, 32'h00);
        chk("pin_t3_F", {24'b0, exp_regs[6]}, 32'h55);

        do_instr(8'h7E, 8'h05, 0);
        do_instr(8'h46, 8'h06, 2);
        do_instr(8'hB8, 8'h00, 0);
        chk("pin_t4_A", {24'b0, exp_regs[7]}, 32'h05);
        chk("pin_t4_F", {24'b0, exp_regs[6]}, 32'h95);

        // Reset while waiting for the immediate aborts the MVI.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h7E;
        step();
        bus.in_valid = 1'b0;
        exp_inst = 8'h7E;
        exp_busy = 1'b1;
        step();
        do_reset();
        chk("pin_t6_A", {24'b0, exp_regs[7]}, 32'h00);
        do_instr(8'h7E, 8'h3C, 5);
        chk("pin_t6_stall_A", {24'b0, exp_regs[7]}, 32'h3C);

        for (int n = 0; n < 200; n++) begin
            code = 8'($urandom);
            if ($urandom_range(0, 9) != 0) code[7:6] = 2'($urandom_range(1, 2));
            if (code == 8'h76) code = 8'h7F;
            do_instr(code, 8'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        do_instr(8'h00, 8'h00, 0);
        step();
        do_instr(8'h76, 8'h00, 0);
        for (int n = 0; n < 20; n++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 8'($urandom);
            step();
        end
        do_reset();
        step();
        do_instr(8'h87, 8'h00, 0);
        chk("pin_post_F", {24'b0, exp_regs[6]}, 32'h44);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
